// File: rtl/keypad_scanner.sv
// keypad_scanner
// 4x4 matrix keypad scanner for the calculator front end. Walks an active-low
// column strobe, synchronizes the active-low rows, debounces press and release,
// and presents the accepted key code with a level key_pressed flag.
// Optional feature: define KEYPAD_REPEAT_EN to enable auto-repeat while a key
// is held (key_pressed drops for one cycle every REPEAT_CNT cycles).
module keypad_scanner #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20000,
    parameter int REPEAT_CNT   = 5000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic        key_pressed,
    output logic [24:0] keypad_out
);

    localparam logic [1:0] SCAN     = 2'd0;
    localparam logic [1:0] DEBOUNCE = 2'd1;
    localparam logic [1:0] HELD     = 2'd2;
    localparam logic [1:0] RELEASE  = 2'd3;

    // Counters are wide enough to hold their parameter value without wrapping.
    localparam int                SCAN_W    = $clog2(SCAN_DIV + 1);
    localparam int                DEB_W     = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CNT - 1);

    // Refuse to elaborate with timing values the state machine cannot honour.
    if (SCAN_DIV < 4 || DEBOUNCE_CNT < 1 || REPEAT_CNT < 2) begin : g_bad_params
        $error("keypad_scanner: SCAN_DIV must be >= 4, DEBOUNCE_CNT >= 1, REPEAT_CNT >= 2");
    end

    logic [3:0]        row_meta;
    logic [3:0]        row_sync;
    logic [1:0]        state;
    logic [1:0]        col_idx;
    logic [1:0]        cand_row;
    logic [SCAN_W-1:0] scan_cnt;
    logic [DEB_W-1:0]  deb_cnt;
    logic [3:0]        code_q;
    logic              row_single;
    logic [1:0]        row_idx;
    logic [3:0]        cand_pattern;

`ifdef KEYPAD_REPEAT_EN
    localparam int               REP_W    = $clog2(REPEAT_CNT + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CNT - 1);
    logic [REP_W-1:0] rep_cnt;
`endif

    // Calculator key layout: rows 1-2-3-A / 4-5-6-B / 7-8-9-C / F-0-E-D.
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0:    code = 4'h1;
            4'h1:    code = 4'h2;
            4'h2:    code = 4'h3;
            4'h3:    code = 4'hA;
            4'h4:    code = 4'h4;
            4'h5:    code = 4'h5;
            4'h6:    code = 4'h6;
            4'h7:    code = 4'hB;
            4'h8:    code = 4'h7;
            4'h9:    code = 4'h8;
            4'hA:    code = 4'h9;
            4'hB:    code = 4'hC;
            4'hC:    code = 4'hF;
            4'hD:    code = 4'h0;
            4'hE:    code = 4'hE;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Decode the synchronized rows: exactly one row low gives a valid candidate.
    always_comb begin
        // NOTE: defaults first so every path assigns every output -- no latch.
        row_single = 1'b1;
        row_idx    = 2'd0;
        case (row_sync)
            4'b1110: row_idx = 2'd0;
            4'b1101: row_idx = 2'd1;
            4'b1011: row_idx = 2'd2;
            4'b0111: row_idx = 2'd3;
            default: row_single = 1'b0;
        endcase
    end

    assign cand_pattern = ~(4'b0001 << cand_row);
    assign col          = ~(4'b0001 << col_idx);
    assign keypad_out   = {21'd0, code_q};

    // Two-flop synchronizer for the asynchronous keypad rows (idle = pulled up).
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so both flops
        // sample their pre-edge values and the chain really is two stages.
        if (reset) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    // Scan / debounce / hold / release sequencing and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= SCAN;
            col_idx     <= 2'd0;
            cand_row    <= 2'd0;
            scan_cnt    <= '0;
            deb_cnt     <= '0;
            key_pressed <= 1'b0;
            code_q      <= 4'h0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt     <= '0;
`endif
        end else begin
            case (state)
                SCAN: begin
                    if (scan_cnt == SCAN_LAST) begin
                        scan_cnt <= '0;
                        if (row_single) begin
                            cand_row <= row_idx;
                            deb_cnt  <= '0;
                            state    <= DEBOUNCE;
                        end else begin
                            col_idx <= col_idx + 2'd1;
                        end
                    end else begin
                        scan_cnt <= scan_cnt + SCAN_W'(1);
                    end
                end
                DEBOUNCE: begin
                    if (row_sync == cand_pattern) begin
                        if (deb_cnt == DEB_LAST) begin
                            deb_cnt     <= '0;
                            code_q      <= key_code(cand_row, col_idx);
                            key_pressed <= 1'b1;
                            state       <= HELD;
`ifdef KEYPAD_REPEAT_EN
                            rep_cnt     <= '0;
`endif
                        end else begin
                            deb_cnt <= deb_cnt + DEB_W'(1);
                        end
                    end else begin
                        // Bounce or a second key: give up and move on.
                        deb_cnt  <= '0;
                        scan_cnt <= '0;
                        col_idx  <= col_idx + 2'd1;
                        state    <= SCAN;
                    end
                end
                HELD: begin
                    if (row_sync != cand_pattern) begin
                        deb_cnt     <= '0;
                        key_pressed <= 1'b1;
                        state       <= RELEASE;
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (rep_cnt == REP_LAST) begin
                        rep_cnt     <= '0;
                        key_pressed <= 1'b0;
                    end else begin
                        rep_cnt     <= rep_cnt + REP_W'(1);
                        key_pressed <= 1'b1;
                    end
`endif
                end
                RELEASE: begin
                    if (row_sync == 4'hF) begin
                        if (deb_cnt == DEB_LAST) begin
                            deb_cnt     <= '0;
                            key_pressed <= 1'b0;
                            col_idx     <= 2'd0;
                            scan_cnt    <= '0;
                            state       <= SCAN;
                        end else begin
                            deb_cnt <= deb_cnt + DEB_W'(1);
                        end
                    end else begin
                        // Contact rebound: still pressed, keep the key asserted.
                        deb_cnt <= '0;
                        state   <= HELD;
`ifdef KEYPAD_REPEAT_EN
                        rep_cnt <= '0;
`endif
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, clock cycles each column is driven before its rows are sampled (>=4).
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 20000, consecutive stable cycles required to accept a press or a release.
REQ-003 SHALL have parameter REPEAT_CNT, default 5000000, cycles between auto-repeat events (used only under Configuration).
REQ-004 clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 row  input  4  keypad rows, active-low, externally pulled up.
REQ-007 col  output  4  keypad columns, active-low, exactly one bit low at any time.
REQ-008 key_pressed  output  1  high while a debounced key is held; consumed by calculator as a rising-edge event.
REQ-009 keypad_out  output  25  key code zero-extended into bits [3:0]; bits [24:4] always 0.

Function
REQ-010 row SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-011 Key map (row,col)->code SHALL be: r0: 1 2 3 A; r1: 4 5 6 B; r2: 7 8 9 C; r3: F 0 E D (A plus, B minus, C multiply, D divide, E clear, F decimal point).
REQ-012 FSM states SHALL be SCAN, DEBOUNCE, HELD, RELEASE.
REQ-013 SCAN: drive col index k for SCAN_DIV cycles, sample rows on the last cycle, then advance k = (k+1) mod 4, wrapping 3->0.
REQ-014 SCAN: exactly one row low at sample -> latch (row,col) candidate, hold col, go DEBOUNCE; zero or more than one row low -> continue scanning (multi-key rejection).
REQ-015 DEBOUNCE: count cycles while the same single row is low; count reaching DEBOUNCE_CNT -> keypad_out <= candidate code, key_pressed <= 1, go HELD; any mismatch -> clear count, return to SCAN at the next column.
REQ-016 keypad_out SHALL update in the same cycle key_pressed rises, and remain stable while key_pressed is high and after release until the next accepted press.
REQ-017 HELD: col stays fixed; candidate row going high (or a second row going low) -> go RELEASE with key_pressed still 1.
REQ-018 RELEASE: count cycles with all rows high; reaching DEBOUNCE_CNT -> key_pressed <= 0, go SCAN at column 0; any row low before then -> return to HELD, count cleared, key_pressed unchanged.
REQ-019 Total latency from stable press to key_pressed high SHALL be at most 4*SCAN_DIV + DEBOUNCE_CNT + 3 cycles (2 synchronizer cycles included).
REQ-020 key_pressed SHALL never pulse for fewer than DEBOUNCE_CNT cycles on bounce shorter than DEBOUNCE_CNT cycles.
REQ-021 Counters SHALL be sized to hold their maximum parameter value without wrap.

Reset
REQ-022 While reset is high: state SCAN, column index 0, col = 4'b1110, key_pressed = 0, keypad_out = 0, counters and synchronizer = all-ones rows / zero counts.
REQ-023 Reset asserted mid-DEBOUNCE, mid-HELD or mid-RELEASE SHALL take effect immediately without waiting for a clock edge; after deassertion scanning restarts from column 0.

Configuration
REQ-024 Macro KEYPAD_REPEAT_EN SHALL enable auto-repeat: in HELD, after REPEAT_CNT cycles held, key_pressed drops for exactly 1 cycle and rises again with keypad_out unchanged, then repeats every REPEAT_CNT cycles.
REQ-025 Without KEYPAD_REPEAT_EN, key_pressed SHALL stay continuously high for the whole HELD/RELEASE duration and the repeat counter SHALL not exist.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=8, REPEAT_CNT=32)
REQ-026 Hold (r1,c2) low clean -> key_pressed rises within 4*4+8+3=27 cycles, keypad_out=25'h6.
REQ-027 Press (r3,c1) with 3-cycle bounce then stable -> single key_pressed rise, keypad_out=25'h0; no pulse during bounce.
REQ-028 Hold (r0,c0) and (r2,c0) simultaneously -> key_pressed stays 0, keypad_out stays 0; col cycles 1110,1101,1011,0111,1110.
REQ-029 Press (r3,c3), release, 4-cycle rebound low, release -> key_pressed high throughout, falls 8 cycles after final release, keypad_out=25'hD retained.
REQ-030 Assert reset while HELD on (r2,c3) -> key_pressed=0, keypad_out=0, col=1110 immediately; after release of reset with key still held, re-accept code 25'hC.
REQ-031 With KEYPAD_REPEAT_EN, hold (r0,c3) 100 cycles -> key_pressed one-cycle low gaps every 32 cycles, keypad_out=25'hA throughout.
